// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding, bus widths and
// the timeout counter sizing helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_IF_BUSY  = 2'b01,
        ARB_MEM_BUSY = 2'b10,
        ARB_DONE     = 2'b11
    } arb_state_e;

    localparam int BYTE_EN_W = 4;
    localparam logic [BYTE_EN_W-1:0] WEN_READ = '0;

    // Bits needed to hold a count from 0 up to and including limit.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// bus_timeout_counter: counts busy cycles without bus_ready for the arbiter.
// Only present when BUS_TIMEOUT_EN is defined.
`ifdef BUS_TIMEOUT_EN
module bus_timeout_counter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int W = cnt_width(LIMIT);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count && (cnt_q != W'(LIMIT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // High in the waiting cycle whose increment makes the count reach LIMIT.
    assign expired = count && (cnt_q == W'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between IF fetches and MEM
// loads/stores, one transaction at a time. BUS_TIMEOUT_EN adds a ready timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 if_req,
    input  logic [ADDR_W-1:0]    if_addr,
    output logic [DATA_W-1:0]    if_rdata,
    output logic                 if_done,
    input  logic                 mem_req,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [BYTE_EN_W-1:0] mem_wen,
    input  logic [DATA_W-1:0]    mem_wdata,
    output logic [DATA_W-1:0]    mem_rdata,
    output logic                 mem_done,
    output logic                 bus_req,
    output logic [ADDR_W-1:0]    bus_addr,
    output logic [BYTE_EN_W-1:0] bus_wen,
    output logic [DATA_W-1:0]    bus_wdata,
    input  logic [DATA_W-1:0]    bus_rdata,
    input  logic                 bus_ready,
    output logic                 bus_err,
    output logic                 stall_all,
    output logic [1:0]           dbg_state
);

    // Handshakes: a requester raises *_req with stable fields and holds it until
    // its one-cycle *_done pulse; bus_req holds bus_* stable until the single
    // bus_ready cycle, which also carries bus_rdata.

    arb_state_e        state_q, state_d;
    logic              grant_mem, grant_if;
    logic              busy, finish, timeout_hit;
    logic              discard_q;
    logic [DATA_W-1:0] resp_data;

    assign grant_mem = mem_req & ~mem_done;
    assign grant_if  = if_req & ~if_done;
    assign busy      = (state_q == ARB_IF_BUSY) || (state_q == ARB_MEM_BUSY);
    assign finish    = busy & (bus_ready | timeout_hit);
    assign resp_data = bus_ready ? bus_rdata : '0;

    assign stall_all = (if_req & ~if_done) | (mem_req & ~mem_done);
    assign dbg_state = state_q;

`ifdef BUS_TIMEOUT_EN
    logic expired;
    logic bus_err_q;

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == ARB_IDLE),
        .count   (busy & ~bus_ready),
        .expired (expired)
    );

    assign timeout_hit = expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= finish & ~bus_ready;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_mem) begin
                    state_d = ARB_MEM_BUSY;
                end else if (grant_if) begin
                    state_d = ARB_IF_BUSY;
                end
            end
            ARB_IF_BUSY, ARB_MEM_BUSY: begin
                if (finish) begin
                    state_d = ARB_DONE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_addr  <= '0;
            bus_wen   <= '0;
            bus_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (grant_mem) begin
                        bus_req   <= 1'b1;
                        bus_addr  <= mem_addr;
                        bus_wen   <= mem_wen;
                        bus_wdata <= mem_wdata;
                        discard_q <= 1'b0;
                    end else if (grant_if) begin
                        bus_req   <= 1'b1;
                        bus_addr  <= if_addr;
                        bus_wen   <= WEN_READ;
                        bus_wdata <= '0;
                        // A flush coinciding with the grant still issues the fetch.
                        discard_q <= flush;
                    end
                end
                ARB_IF_BUSY: begin
                    if (finish) begin
                        bus_req  <= 1'b0;
                        if_rdata <= resp_data;
                        if_done  <= ~(discard_q | flush);
                    end else begin
                        discard_q <= discard_q | flush;
                    end
                end
                ARB_MEM_BUSY: begin
                    if (finish) begin
                        bus_req   <= 1'b0;
                        mem_rdata <= resp_data;
                        mem_done  <= 1'b1;
                    end
                end
                default: begin
                    discard_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a transaction-level model predicts every
// output each cycle, and a literal queue pins the done cycles and data.
module tb_mem_bus_arbiter;

`ifdef BUS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mem_req = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [3:0]  mem_wen = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wen;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_err;
    logic        stall_all;
    logic [1:0]  dbg_state;

    mem_bus_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_wen   (bus_wen),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .bus_err   (bus_err),
        .stall_all (stall_all),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model state and slave configuration ----------------
    int          if_delay = 1, mem_delay = 1;   // bus cycles until ready; 0 = never
    logic [31:0] if_rd = '0, mem_rd = '0;
    bit          m_active = 0, m_mem = 0, m_disc = 0, m_to = 0;
    int          m_g = 0, m_r = 0, m_free = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_wen = '0;
    bit          if_drop = 0, mem_drop = 0;

    assign bus_ready = rst_n && m_active && !m_to && (cyc == m_r);
    assign bus_rdata = (m_active && cyc == m_r) ? m_rdata : 32'h5a5a5a5a;

    // ---------------- scoreboard ----------------
    int          total = 0, bad = 0;
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int n, dly;
        bit e_req, dc, e_ifd, e_memd, e_err;
        n = cyc;
        if (!rst_n) begin
            check("rst_bus_req", bus_req, 0);
            check("rst_if_done", if_done, 0);
            check("rst_mem_done", mem_done, 0);
            check("rst_bus_err", bus_err, 0);
            check("rst_bus_addr", bus_addr, 0);
            check("rst_bus_wen", bus_wen, 0);
            check("rst_bus_wdata", bus_wdata, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_mem_rdata", mem_rdata, 0);
            check("rst_state", dbg_state, 0);
            m_active = 0;
            m_free   = n + 1;
            if_drop  = 0;
            mem_drop = 0;
        end else begin
            e_req  = m_active && (n > m_g) && (n <= m_r);
            dc     = m_active && (n == m_r + 1);
            e_ifd  = dc && !m_mem && !m_disc;
            e_memd = dc && m_mem;
            e_err  = dc && m_to;
            check("bus_req", bus_req, e_req);
            check("if_done", if_done, e_ifd);
            check("mem_done", mem_done, e_memd);
            check("bus_err", bus_err, e_err);
            check("stall_all", stall_all, (if_req && !e_ifd) || (mem_req && !e_memd));
            if (e_req) begin
                check("bus_addr", bus_addr, m_addr);
                check("bus_wen", bus_wen, m_wen);
                if (m_mem) check("bus_wdata", bus_wdata, m_wdata);
            end
            if (e_ifd) check("if_rdata", if_rdata, m_to ? 32'h0 : m_rdata);
            if (e_memd) check("mem_rdata", mem_rdata, m_to ? 32'h0 : m_rdata);

            if (if_done || mem_done) begin
                if (exp_q.size() == 0) begin
                    check("extra_done", {if_done, mem_done}, 2'b00);
                end else begin
                    check("done_cycle", n, exp_cyc_q.pop_front());
                    check("done_data", if_done ? if_rdata : mem_rdata, exp_q.pop_front());
                end
            end

            // advance the model with this cycle's inputs
            if (m_active && !m_mem && n > m_g && n <= m_r && flush) m_disc = 1;
            if (dc) m_active = 0;
            if (!m_active && n >= m_free && ((mem_req && !e_memd) || (if_req && !e_ifd))) begin
                m_active = 1;
                m_g      = n;
                m_mem    = mem_req && !e_memd;
                dly      = m_mem ? mem_delay : if_delay;
`ifdef BUS_TIMEOUT_EN
                m_to     = (dly == 0) || (dly > TO);
`else
                m_to     = 0;
`endif
                m_r      = m_to ? n + TO : n + dly;
                m_free   = m_r + 2;
                m_addr   = m_mem ? mem_addr : if_addr;
                m_wen    = m_mem ? mem_wen : 4'b0000;
                m_wdata  = mem_wdata;
                m_rdata  = m_mem ? mem_rd : if_rd;
                m_disc   = m_mem ? 1'b0 : flush;
            end
            if_drop  = e_ifd;
            mem_drop = e_memd;
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (if_drop) if_req = 1'b0;
        if (mem_drop) mem_req = 1'b0;
    endtask

    task automatic expect_done(input int at, input logic [31:0] data);
        exp_cyc_q.push_back(at);
        exp_q.push_back(data);
    endtask

    initial begin
        int t0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // IF only, ready on the first bus cycle
        if_delay = 1; if_rd = 32'h24080001;
        step(); t0 = cyc;
        if_req = 1'b1; if_addr = 32'hbfc00000;
        expect_done(t0 + 2, 32'h24080001);
        repeat (5) step();

        // simultaneous requests: MEM store first, then IF
        mem_delay = 1; mem_rd = 32'h00000000; if_rd = 32'h3c1d8000;
        step(); t0 = cyc;
        mem_req = 1'b1; mem_addr = 32'h80000010; mem_wen = 4'b1111; mem_wdata = 32'hdeadbeef;
        if_req = 1'b1; if_addr = 32'hbfc00004;
        expect_done(t0 + 2, 32'h00000000);
        expect_done(t0 + 5, 32'h3c1d8000);
        repeat (8) step();

        // flush during an IF fetch: discarded, refetch granted at cycle 5
        if_delay = 3; if_rd = 32'h11112222;
        step(); t0 = cyc;
        if_req = 1'b1; if_addr = 32'hbfc00008;
        step();
        flush = 1'b1; if_addr = 32'hbfc00380; if_delay = 1; if_rd = 32'h3c1a0040;
        step();
        flush = 1'b0;
        expect_done(t0 + 7, 32'h3c1a0040);
        repeat (7) step();

        // MEM load with ready late; flush mid-transaction is ignored
        mem_delay = 7; mem_rd = 32'hcafef00d;
        step(); t0 = cyc;
        mem_req = 1'b1; mem_addr = 32'h80000020; mem_wen = 4'b0000; mem_wdata = 32'h0;
`ifdef BUS_TIMEOUT_EN
        expect_done(t0 + TO + 1, 32'h00000000);
`else
        expect_done(t0 + 8, 32'hcafef00d);
`endif
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (7) step();

        // reset during MEM_BUSY, request re-granted after release
        mem_delay = 3; mem_rd = 32'h0bad0bad;
        step(); t0 = cyc;
        mem_req = 1'b1; mem_addr = 32'h80000030; mem_wen = 4'b0011; mem_wdata = 32'h12345678;
        step();
        step();
        rst_n = 1'b0; mem_delay = 1; mem_rd = 32'h600dcafe;
        step();
        rst_n = 1'b1;
        expect_done(t0 + 5, 32'h600dcafe);
        repeat (5) step();

`ifdef BUS_TIMEOUT_EN
        // ready never comes: forced completion with zero data and bus_err
        if_delay = 0; if_rd = 32'hffffffff;
        step(); t0 = cyc;
        if_req = 1'b1; if_addr = 32'hbfc00100;
        expect_done(t0 + TO + 1, 32'h00000000);
        repeat (TO + 5) step();
`endif

        check("pending_done", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

endmodule
